mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Sits directly downstream of the memory buffer: takes one ordered load/store op at a time.
//  Drives the single-port data-memory request/grant/response interface.
//  Returns completion to the ROB; loads also return data on the writeback bus.
//  Exactly one op is in flight; its hold-off is what sequences the memory buffer's pops.
// PARAMETERS
//  ADDR_W  16  data-memory address width
//  DATA_W  16  data width (load result / store data)
//  TAG_W   6   physical destination register tag width
//  ROB_W   5   ROB index width
// PORTS
//  clk          in   1       clock, rising edge
//  n_rst        in   1       asynchronous reset, ACTIVE-HIGH (n_rst=1 resets)
//  flush        in   1       pipeline squash; kill the in-flight op's writeback
//  in_valid     in   1       memory buffer has an op ready (its 'valid')
//  in_ready     out  1       unit can accept an op this cycle
//  in_op        in   mem_op_t  {is_store, addr[ADDR_W], wdata[DATA_W], tag[TAG_W], rob[ROB_W]}
//  dm_req       out  1       data-memory request
//  dm_we        out  1       1=store, 0=load
//  dm_addr      out  ADDR_W  request address
//  dm_wdata     out  DATA_W  store data
//  dm_gnt       in   1       memory accepted request this cycle
//  dm_rvalid    in   1       response valid (load data or store ack)
//  dm_rdata     in   DATA_W  load data
//  wb_valid     out  1       completion valid
//  wb_ready     in   1       writeback/ROB consumes completion
//  wb_is_load   out  1       1 = wb_tag/wb_data are meaningful
//  wb_tag       out  TAG_W   destination tag (loads)
//  wb_data      out  DATA_W  load result
//  wb_rob       out  ROB_W   ROB entry to mark complete
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0 except in_ready=1; the op register is cleared.
//  - FSM with four states: IDLE, REQ, WAIT and WB.
//    IDLE: in_ready=1; on in_valid, latch in_op into the op register and go to REQ.
//          If flush is also high that cycle, the op is still latched but marked killed.
//    REQ:  dm_req=1; dm_we/addr/wdata come from the op register and are held stable until dm_gnt.
//          On dm_gnt, go to WAIT; if dm_rvalid arrives the same cycle, go straight to WB (or IDLE if killed).
//    WAIT: on dm_rvalid, capture dm_rdata (loads only) and go to WB, or to IDLE if killed.
//    WB:   wb_valid=1 with the fields registered; go to IDLE when wb_ready.
//  - Latency: accept at cycle 0 -> dm_req at cycle 1 -> wb_valid at cycle (grant + 1 + response delay) at earliest.
//    With a same-cycle dm_gnt and dm_rvalid, wb_valid is asserted at cycle 2.
//  - in_ready is low in REQ, WAIT and WB, so the memory buffer must not pop while in_ready=0.
//  - Flush handling:
//    In REQ before grant: drop dm_req next cycle and return to IDLE; no memory access occurs.
//    In WAIT: set the kill flag and keep waiting for dm_rvalid so the response is drained; then go to IDLE with no wb_valid.
//    In WB: deassert wb_valid next cycle and return to IDLE.
//  - Stores: wb_is_load=0; wb_tag/wb_data are 0; the completion carries only wb_rob.
//  - All fields are unsigned; no address arithmetic; dm_addr=addr passes through unchanged.
//  - Reset asserted mid-transaction: immediate return to IDLE; any outstanding response is ignored after reset.
//  - dm_rvalid while in IDLE or REQ-without-grant is a protocol error: ignore it and flag an assertion in simulation.
// STRUCTURE
//  - Shared nand_cpu package holds mem_op_t (packed struct above) and mau_state_t enum {IDLE,REQ,WAIT,WB}.
//  - Single module: FSM plus one op register plus one result register; no sub-modules.
// TESTING
//  - Load, gnt same cycle, rvalid 2 cycles later:
//    op{ld,addr=0x0040,tag=5,rob=3}, rdata=0xBEEF -> wb_valid with tag=5, data=0xBEEF, rob=3, is_load=1.
//  - Store with 3-cycle grant stall:
//    op{st,addr=0x1000,wdata=0x1234,rob=7} -> dm_req/addr/wdata held for 3 cycles;
//    after ack, wb_valid with rob=7, is_load=0, data=0.
//  - wb_ready held low for 4 cycles -> wb_valid and fields stay stable, in_ready=0 throughout, the next in_valid is not accepted.
//  - flush during WAIT of a load -> no wb_valid; unit returns to IDLE only after dm_rvalid;
//    the next op (rob=9) completes normally.
//  - flush in REQ before grant -> dm_req drops the next cycle, no dm_gnt is consumed, in_ready=1 two cycles after the flush.
//  - n_rst pulse while in WAIT -> outputs take reset values asynchronously;
//    a later stale dm_rvalid produces no wb_valid.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
// Shared types for the load/store back end of the nand_cpu core.
//   mem_op_t    : one ordered memory operation handed over by the memory buffer
//   mau_state_t : sequencing states of the memory access unit
package nand_cpu_pkg;

  localparam int MEM_ADDR_W = 16;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_TAG_W  = 6;
  localparam int MEM_ROB_W  = 5;

  typedef struct packed {
    logic                  is_store;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
    logic [MEM_TAG_W-1:0]  tag;
    logic [MEM_ROB_W-1:0]  rob;
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    WB   = 2'd3
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Takes one ordered load/store from the memory buffer at a time, runs it over the
//   single-port data-memory req/gnt/rvalid interface and returns the completion to
//   the ROB (loads also return their data on the writeback bus). Only one op is ever
//   in flight, so in_ready doubles as the memory buffer's pop enable.
// Ports
//   clk, n_rst          clock (rising edge), asynchronous active-high reset
//   flush               squash: the in-flight op must not write back
//   in_valid/in_ready   op handshake from the memory buffer, in_op carries the op
//   dm_req/we/addr/wdata  data-memory request, held stable until dm_gnt
//   dm_gnt              memory accepted the request this cycle
//   dm_rvalid/dm_rdata  memory response (load data or store ack)
//   wb_valid/wb_ready   completion handshake towards writeback/ROB
//   wb_is_load/tag/data/rob  completion fields (tag/data are 0 for stores)
module mem_access_unit
  import nand_cpu_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_DATA_W,
  parameter int TAG_W  = MEM_TAG_W,
  parameter int ROB_W  = MEM_ROB_W
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  mem_op_t           in_op,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_is_load,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [DATA_W-1:0] wb_data,
  output logic [ROB_W-1:0]  wb_rob
);

  mau_state_t        r_state;
  mau_state_t        w_state_next;
  mem_op_t           r_op;
  logic              r_killed;
  logic              w_killed_next;
  logic              w_accept;
  logic              w_capture;
  logic              w_req;
  logic              r_wb_is_load;
  logic [TAG_W-1:0]  r_wb_tag;
  logic [DATA_W-1:0] r_wb_data;
  logic [ROB_W-1:0]  r_wb_rob;
  // Set by reset until the first grant: a response that was outstanding when reset
  // hit may still arrive and must be silently dropped rather than flagged.
  logic              r_rst_drain;

  always_comb begin
    w_state_next  = r_state;
    w_killed_next = r_killed;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_accept      = 1'b1;
          w_killed_next = flush;
          w_state_next  = REQ;
        end
      end
      REQ: begin
        if (dm_gnt) begin
          // Once granted the access is committed: a flush only suppresses writeback.
          if (dm_rvalid) begin
            if (r_killed || flush) begin
              w_state_next = IDLE;
            end else begin
              w_capture    = 1'b1;
              w_state_next = WB;
            end
          end else begin
            w_killed_next = r_killed | flush;
            w_state_next  = WAIT;
          end
        end else if (flush) begin
          // Not granted yet: abandon the request, memory never sees it.
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        w_killed_next = r_killed | flush;
        if (dm_rvalid) begin
          if (r_killed || flush) begin
            w_state_next = IDLE;
          end else begin
            w_capture    = 1'b1;
            w_state_next = WB;
          end
        end
      end
      WB: begin
        if (flush || wb_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      r_state      <= IDLE;
      r_op         <= '0;
      r_killed     <= 1'b0;
      r_wb_is_load <= 1'b0;
      r_wb_tag     <= '0;
      r_wb_data    <= '0;
      r_wb_rob     <= '0;
      r_rst_drain  <= 1'b1;
    end else begin
      r_state  <= w_state_next;
      r_killed <= w_killed_next;
      if (w_accept) begin
        r_op <= in_op;
      end
      if (w_capture) begin
        r_wb_is_load <= ~r_op.is_store;
        r_wb_tag     <= r_op.is_store ? '0 : r_op.tag;
        r_wb_data    <= r_op.is_store ? '0 : dm_rdata;
        r_wb_rob     <= r_op.rob;
      end
      if (w_req && dm_gnt) begin
        r_rst_drain <= 1'b0;
      end
    end
  end

  assign w_req      = (r_state == REQ);
  assign in_ready   = (r_state == IDLE);
  assign dm_req     = w_req;
  assign dm_we      = w_req & r_op.is_store;
  assign dm_addr    = w_req ? r_op.addr : '0;
  assign dm_wdata   = (w_req && r_op.is_store) ? r_op.wdata : '0;
  assign wb_valid   = (r_state == WB);
  assign wb_is_load = r_wb_is_load;
  assign wb_tag     = r_wb_tag;
  assign wb_data    = r_wb_data;
  assign wb_rob     = r_wb_rob;

`ifndef SYNTHESIS
  // A response with nothing granted outstanding is a memory-side protocol error.
  logic w_stray_rvalid;
  assign w_stray_rvalid = dm_rvalid && !r_rst_drain &&
                          ((r_state == IDLE) || ((r_state == REQ) && !dm_gnt));
  a_no_stray_rvalid : assert property (@(posedge clk) disable iff (n_rst) !w_stray_rvalid);
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import nand_cpu_pkg::*;

  logic        clk;
  logic        n_rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  mem_op_t     in_op;
  logic        dm_req;
  logic        dm_we;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [15:0] dm_rdata;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_is_load;
  logic [5:0]  wb_tag;
  logic [15:0] wb_data;
  logic [4:0]  wb_rob;

  int checks = 0;
  int errors = 0;

  // Reference memory: what the data memory holds, keyed by address.
  logic [15:0] mem_model [logic [15:0]];

  mem_access_unit dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_is_load (wb_is_load),
    .wb_tag     (wb_tag),
    .wb_data    (wb_data),
    .wb_rob     (wb_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 16'hA5A5;
  endfunction

  function automatic mem_op_t rand_op();
    mem_op_t op;
    op.is_store = 1'($urandom_range(0, 1));
    op.addr     = 16'h0100 + 16'($urandom_range(0, 7)) * 16'h0010;
    op.wdata    = 16'($urandom);
    op.tag      = 6'($urandom);
    op.rob      = 5'($urandom);
    return op;
  endfunction

  function automatic mem_op_t make_op(input logic st, input logic [15:0] a, input logic [15:0] wd,
                                      input logic [5:0] tg, input logic [4:0] rb);
    mem_op_t op;
    op.is_store = st;
    op.addr     = a;
    op.wdata    = wd;
    op.tag      = tg;
    op.rob      = rb;
    return op;
  endfunction

  // Wait (bounded) for in_ready, then present op for one cycle.
  task automatic accept_op(input string name, input mem_op_t op, input logic with_flush);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout in_ready=%b required 1", name, in_ready);
    end
    in_valid = 1'b1;
    in_op    = op;
    flush    = with_flush;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    in_op    = rand_op();
  endtask

  // Full transaction: grant after gnt_dly stall cycles, response rsp_dly cycles
  // after grant (0 = same cycle), wb_ready withheld for wbr_dly cycles.
  task automatic run_op(input string name, input mem_op_t op, input int gnt_dly,
                        input int rsp_dly, input int wbr_dly, input bit probe);
    logic        exp_load;
    logic [5:0]  exp_tag;
    logic [15:0] exp_data;
    logic [15:0] rsp;
    exp_load = !op.is_store;
    exp_tag  = op.is_store ? 6'd0 : op.tag;
    exp_data = op.is_store ? 16'd0 : mem_read(op.addr);
    rsp      = op.is_store ? 16'($urandom) : mem_read(op.addr);

    accept_op(name, op, 1'b0);
    for (int i = 0; i <= gnt_dly; i++) begin
      checks++;
      if ({dm_req, dm_we, dm_addr} !== {1'b1, op.is_store, op.addr} ||
          (op.is_store && dm_wdata !== op.wdata) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s req_fields req=%b we=%b addr=%h wdata=%h rdy=%b required 1 %b %h %h 0",
                 name, dm_req, dm_we, dm_addr, dm_wdata, in_ready, op.is_store, op.addr, op.wdata);
      end
      if (i == gnt_dly) begin
        dm_gnt = 1'b1;
        if (op.is_store) mem_model[op.addr] = op.wdata;
        if (rsp_dly == 0) begin
          dm_rvalid = 1'b1;
          dm_rdata  = rsp;
        end
      end
      tick();
    end
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    if (rsp_dly > 0) begin
      for (int i = 0; i < rsp_dly - 1; i++) begin
        checks++;
        if (wb_valid !== 1'b0 || dm_req !== 1'b0 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s wait_state wb_valid=%b dm_req=%b in_ready=%b required 0 0 0",
                   name, wb_valid, dm_req, in_ready);
        end
        tick();
      end
      dm_rvalid = 1'b1;
      dm_rdata  = rsp;
      tick();
      dm_rvalid = 1'b0;
    end
    dm_rdata = 16'($urandom);

    for (int i = 0; i <= wbr_dly; i++) begin
      checks++;
      if ({wb_valid, wb_is_load, wb_tag, wb_data, wb_rob, in_ready} !==
          {1'b1, exp_load, exp_tag, exp_data, op.rob, 1'b0}) begin
        errors++;
        $display("FAIL %s completion vld=%b ld=%b tag=%0d data=%h rob=%0d rdy=%b required 1 %b %0d %h %0d 0",
                 name, wb_valid, wb_is_load, wb_tag, wb_data, wb_rob, in_ready,
                 exp_load, exp_tag, exp_data, op.rob);
      end
      if (i < wbr_dly) begin
        wb_ready = 1'b0;
        if (probe) begin
          in_valid = 1'b1;
          in_op    = rand_op();
        end
      end else begin
        in_valid = 1'b0;
        wb_ready = 1'b1;
      end
      tick();
    end
    wb_ready = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1 || dm_req !== 1'b0) begin
      errors++;
      $display("FAIL %s retire wb_valid=%b in_ready=%b dm_req=%b required 0 1 0",
               name, wb_valid, in_ready, dm_req);
    end
    if (probe) begin
      tick();
      checks++;
      if (in_ready !== 1'b1 || dm_req !== 1'b0) begin
        errors++;
        $display("FAIL %s probe_not_taken in_ready=%b dm_req=%b required 1 0", name, in_ready, dm_req);
      end
    end
    $display("%s: st=%b addr=%h rob=%0d gnt_dly=%0d rsp_dly=%0d wbr_dly=%0d -> ld=%b tag=%0d data=%h",
             name, op.is_store, op.addr, op.rob, gnt_dly, rsp_dly, wbr_dly, exp_load, exp_tag, exp_data);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dm_req, dm_we, dm_addr, dm_wdata, wb_valid, wb_is_load, wb_tag, wb_data, wb_rob} !== '0 ||
        in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values in_ready=%b req=%b we=%b addr=%h wdata=%h wbv=%b ld=%b tag=%0d data=%h rob=%0d required in_ready=1 rest 0",
               in_ready, dm_req, dm_we, dm_addr, dm_wdata, wb_valid, wb_is_load, wb_tag, wb_data, wb_rob);
    end
    n_rst = 1'b0;
    tick();
    $display("reset: released");
  endtask

  task automatic test_load();
    mem_model[16'h0040] = 16'hBEEF;
    run_op("load_rsp2", make_op(1'b0, 16'h0040, 16'h0000, 6'd5, 5'd3), 0, 2, 0, 1'b0);
    // Same-cycle grant and response: completion visible two cycles after accept.
    mem_model[16'h0200] = 16'h5A5A;
    run_op("load_min_latency", make_op(1'b0, 16'h0200, 16'hFFFF, 6'd33, 5'd12), 0, 0, 0, 1'b0);
  endtask

  task automatic test_store_stall();
    run_op("store_stall", make_op(1'b1, 16'h1000, 16'h1234, 6'd21, 5'd7), 3, 1, 0, 1'b0);
    // Later load sees the stored data.
    run_op("load_after_store", make_op(1'b0, 16'h1000, 16'h0000, 6'd9, 5'd8), 1, 1, 0, 1'b0);
  endtask

  task automatic test_wb_backpressure();
    run_op("wb_backpressure", make_op(1'b0, 16'h0040, 16'h0000, 6'd44, 5'd20), 0, 1, 4, 1'b1);
  endtask

  task automatic test_flush_wait();
    accept_op("flush_wait", make_op(1'b0, 16'h0300, 16'h0000, 6'd2, 5'd4), 1'b0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    flush  = 1'b1;
    tick();
    flush  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (in_ready !== 1'b0 || wb_valid !== 1'b0 || dm_req !== 1'b0) begin
        errors++;
        $display("FAIL flush_wait draining in_ready=%b wb_valid=%b dm_req=%b required 0 0 0",
                 in_ready, wb_valid, dm_req);
      end
      tick();
    end
    dm_rvalid = 1'b1;
    dm_rdata  = 16'hDEAD;
    tick();
    dm_rvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_wait drained wb_valid=%b in_ready=%b required 0 1", wb_valid, in_ready);
    end
    $display("flush_wait: killed load drained, no completion");
    run_op("after_flush_wait", make_op(1'b0, 16'h0300, 16'h0000, 6'd11, 5'd9), 0, 1, 0, 1'b0);
  endtask

  task automatic test_flush_req();
    accept_op("flush_req", make_op(1'b1, 16'h0400, 16'h7777, 6'd0, 5'd10), 1'b0);
    checks++;
    if (dm_req !== 1'b1) begin
      errors++;
      $display("FAIL flush_req req_up dm_req=%b required 1", dm_req);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (dm_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_req req_dropped dm_req=%b wb_valid=%b required 0 0", dm_req, wb_valid);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1 || dm_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_req idle in_ready=%b dm_req=%b wb_valid=%b required 1 0 0",
               in_ready, dm_req, wb_valid);
    end
    $display("flush_req: request abandoned before grant");
  endtask

  task automatic test_flush_on_accept();
    accept_op("flush_accept", make_op(1'b0, 16'h0500, 16'h0000, 6'd7, 5'd15), 1'b1);
    checks++;
    if (dm_req !== 1'b1 || dm_addr !== 16'h0500) begin
      errors++;
      $display("FAIL flush_accept req dm_req=%b addr=%h required 1 0500", dm_req, dm_addr);
    end
    dm_gnt    = 1'b1;
    dm_rvalid = 1'b1;
    dm_rdata  = 16'h1111;
    tick();
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    checks++;
    if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_accept no_wb wb_valid=%b in_ready=%b required 0 1", wb_valid, in_ready);
    end
    $display("flush_accept: killed-at-accept load gave no completion");
  endtask

  task automatic test_reset_in_wait();
    accept_op("rst_wait", make_op(1'b0, 16'h0600, 16'h0000, 6'd3, 5'd1), 1'b0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    #2;
    n_rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || dm_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait async in_ready=%b dm_req=%b wb_valid=%b required 1 0 0",
               in_ready, dm_req, wb_valid);
    end
    #1;
    n_rst = 1'b0;
    tick();
    dm_rvalid = 1'b1;
    dm_rdata  = 16'hCAFE;
    tick();
    dm_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_wait stale_rsp wb_valid=%b in_ready=%b required 0 1", wb_valid, in_ready);
      end
      tick();
    end
    $display("rst_wait: reset mid-wait, stale response ignored");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      run_op($sformatf("rand%0d", k), rand_op(), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_rst     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    dm_gnt    = 1'b0;
    dm_rvalid = 1'b0;
    dm_rdata  = '0;
    wb_ready  = 1'b0;
    test_reset();
    test_load();
    test_store_stall();
    test_wb_backpressure();
    test_flush_wait();
    test_flush_req();
    test_flush_on_accept();
    test_reset_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
